// File: rtl/fp_ctrl_pipe_if.sv
// Handshake/control bundle for fp_ctrl_pipe: Decode instruction and
// Execute flags in, per-stage control out.
interface fp_ctrl_pipe_if;
  logic [31:0] InstrD;
  logic        ZeroE;
  logic        LtE;
  logic        FlushE;
  logic [1:0]  ImmSrcD;
  logic        IsFpD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic        IsFpE;
  logic [1:0]  FpOpE;
  logic        PCSrcE;
  logic        FpStallE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  modport master (
    output InstrD, ZeroE, LtE, FlushE,
    input  ImmSrcD, IsFpD, ALUSrcE, ALUControlE, ResultSrcE, IsFpE, FpOpE,
           PCSrcE, FpStallE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW
  );

  modport slave (
    input  InstrD, ZeroE, LtE, FlushE,
    output ImmSrcD, IsFpD, ALUSrcE, ALUControlE, ResultSrcE, IsFpE, FpOpE,
           PCSrcE, FpStallE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW
  );
endinterface

// File: rtl/fp_ctrl_pipe.sv
// Pipelined control unit: decodes the instruction in D and carries control
// through D/E, E/M and M/W. Multi-cycle FP ops hold E via a busy counter
// while bubbles drain into M.
module fp_ctrl_pipe #(
  parameter int FP_LAT     = 3,
  parameter int EXT_BRANCH = 1
) (
  input logic           clk,
  input logic           reset,
  fp_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       aluSrc;
    logic [2:0] aluControl;
    logic       branch;
    logic       jump;
    logic       isFp;
    logic [1:0] fpOp;
    logic [2:0] funct3;
  } ctrlE_t;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
  } ctrlM_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
  } ctrlW_t;

  localparam logic [3:0] LAT_M1 = 4'(FP_LAT - 1);

  ctrlE_t     ctrlD, ctrlE;
  ctrlM_t     ctrlM;
  ctrlW_t     ctrlW;
  logic [1:0] immSrcD;
  logic [3:0] busyCnt;
  logic       fpStall;
  logic       cond;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       unusedBits;

  assign op = bus.InstrD[6:0];
  assign f3 = bus.InstrD[14:12];
  assign f7 = bus.InstrD[31:25];
  assign unusedBits = ^{bus.InstrD[24:15], bus.InstrD[11:7]};

  // Integer ALU op from funct3; sub only when the caller allows it
  function automatic logic [2:0] aluDec(input logic [2:0] fn3, input logic sub);
    case (fn3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Main decoder: unknown opcodes leave every control at zero
  always_comb begin
    ctrlD        = '0;
    immSrcD      = 2'b00;
    ctrlD.funct3 = f3;
    case (op)
      7'b0000011: begin ctrlD.regWrite = 1'b1; ctrlD.aluSrc = 1'b1; ctrlD.resultSrc = 2'b01; end
      7'b0100011: begin ctrlD.memWrite = 1'b1; ctrlD.aluSrc = 1'b1; immSrcD = 2'b01; end
      7'b0110011: begin ctrlD.regWrite = 1'b1; ctrlD.aluControl = aluDec(f3, f7[5]); end
      7'b0010011: begin
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.aluControl = aluDec(f3, 1'b0);
      end
      7'b1100011: begin ctrlD.branch = 1'b1; ctrlD.aluControl = 3'b001; immSrcD = 2'b10; end
      7'b1101111: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.resultSrc = 2'b10;
        immSrcD         = 2'b11;
      end
      7'b1010011: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.resultSrc = 2'b11;
        ctrlD.isFp      = 1'b1;
        case (f7)
          7'b0100000: ctrlD.fpOp = 2'b01;
          7'b0000001: ctrlD.fpOp = 2'b10;
          7'b0001100: ctrlD.fpOp = 2'b11;
          default:    ctrlD.fpOp = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign fpStall = (busyCnt != 4'd0);

  // Branch condition from the funct3 carried into E
  always_comb begin
    cond = 1'b0;
    if (EXT_BRANCH == 0) cond = bus.ZeroE;
    else begin
      case (ctrlE.funct3)
        3'b000:  cond = bus.ZeroE;
        3'b001:  cond = !bus.ZeroE;
        3'b100:  cond = bus.LtE;
        3'b101:  cond = !bus.LtE;
        default: cond = 1'b0;
      endcase
    end
  end

  // D/E register plus FP busy counter; stall hold beats FlushE
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlE   <= '0;
      busyCnt <= '0;
    end else if (fpStall) begin
      busyCnt <= busyCnt - 4'd1;
    end else if (bus.FlushE) begin
      ctrlE   <= '0;
      busyCnt <= '0;
    end else begin
      ctrlE   <= ctrlD;
      busyCnt <= (ctrlD.isFp && FP_LAT > 1) ? LAT_M1 : 4'd0;
    end
  end

  // E/M register: takes a bubble while the FP op is still busy in E
  always_ff @(posedge clk) begin
    if (reset || fpStall) ctrlM <= '0;
    else                  ctrlM <= '{ctrlE.regWrite, ctrlE.memWrite, ctrlE.resultSrc};
  end

  // M/W register: advances every cycle
  always_ff @(posedge clk) begin
    if (reset) ctrlW <= '0;
    else       ctrlW <= '{ctrlM.regWrite, ctrlM.resultSrc};
  end

  assign bus.ImmSrcD     = immSrcD;
  assign bus.IsFpD       = ctrlD.isFp;
  assign bus.ALUSrcE     = ctrlE.aluSrc;
  assign bus.ALUControlE = ctrlE.aluControl;
  assign bus.ResultSrcE  = ctrlE.resultSrc;
  assign bus.IsFpE       = ctrlE.isFp;
  assign bus.FpOpE       = ctrlE.fpOp;
  assign bus.PCSrcE      = !fpStall && (ctrlE.jump || (ctrlE.branch && cond));
  assign bus.FpStallE    = fpStall;
  assign bus.RegWriteM   = ctrlM.regWrite;
  assign bus.MemWriteM   = ctrlM.memWrite;
  assign bus.RegWriteW   = ctrlW.regWrite;
  assign bus.ResultSrcW  = ctrlW.resultSrc;

endmodule

// File: tb/tb_fp_ctrl_pipe.sv
// Bench for fp_ctrl_pipe: two instances (FP_LAT=3/EXT_BRANCH=1 and
// FP_LAT=1/EXT_BRANCH=0) share one directed stimulus stream. A stage-occupancy
// model predicts every output each cycle; literal checks pin key cases.
module tb_fp_ctrl_pipe;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] SUB   = 32'h4020_81B3;
  localparam logic [31:0] LW    = 32'h0000_A183;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] BNE   = 32'h0020_9063;
  localparam logic [31:0] BLT   = 32'h0020_C063;
  localparam logic [31:0] JAL   = 32'h0000_00EF;
  localparam logic [31:0] FMUL  = 32'h0220_81D3;
  localparam logic [31:0] FDIV  = 32'h1820_81D3;
  localparam logic [31:0] UNDEF = 32'h0000_007F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instrD;
  logic        zeroE, ltE, flushE;
  int          checks = 0;
  int          failures = 0;

  fp_ctrl_pipe_if if0();
  fp_ctrl_pipe_if if1();
  assign if0.InstrD = instrD;  assign if1.InstrD = instrD;
  assign if0.ZeroE  = zeroE;   assign if1.ZeroE  = zeroE;
  assign if0.LtE    = ltE;     assign if1.LtE    = ltE;
  assign if0.FlushE = flushE;  assign if1.FlushE = flushE;

  fp_ctrl_pipe #(.FP_LAT(3), .EXT_BRANCH(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  fp_ctrl_pipe #(.FP_LAT(1), .EXT_BRANCH(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  logic [18:0] act [2];
  assign act[0] = {if0.ImmSrcD, if0.IsFpD, if0.ALUSrcE, if0.ALUControlE, if0.ResultSrcE,
                   if0.IsFpE, if0.FpOpE, if0.PCSrcE, if0.FpStallE, if0.RegWriteM,
                   if0.MemWriteM, if0.RegWriteW, if0.ResultSrcW};
  assign act[1] = {if1.ImmSrcD, if1.IsFpD, if1.ALUSrcE, if1.ALUControlE, if1.ResultSrcE,
                   if1.IsFpE, if1.FpOpE, if1.PCSrcE, if1.FpStallE, if1.RegWriteM,
                   if1.MemWriteM, if1.RegWriteW, if1.ResultSrcW};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       aluSrc;
    logic [2:0] aluCtl;
    logic       branch;
    logic       jump;
    logic [1:0] immSrc;
    logic       isFp;
    logic [1:0] fpOp;
  } dec_t;

  function automatic logic [2:0] aluFor(input logic [2:0] fn3, input logic subBit);
    if (fn3 == 3'd0) return subBit ? 3'b001 : 3'b000;
    if (fn3 == 3'd2) return 3'b101;
    if (fn3 == 3'd6) return 3'b011;
    if (fn3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t r;
    logic [6:0] opc, fn7;
    r   = '0;
    opc = ins[6:0];
    fn7 = ins[31:25];
    if (opc == 7'h03)      begin r.regWrite = 1; r.aluSrc = 1; r.resultSrc = 2'b01; end
    else if (opc == 7'h23) begin r.memWrite = 1; r.aluSrc = 1; r.immSrc = 2'b01; end
    else if (opc == 7'h33) begin r.regWrite = 1; r.aluCtl = aluFor(ins[14:12], fn7[5]); end
    else if (opc == 7'h13) begin r.regWrite = 1; r.aluSrc = 1; r.aluCtl = aluFor(ins[14:12], 1'b0); end
    else if (opc == 7'h63) begin r.branch = 1; r.immSrc = 2'b10; r.aluCtl = 3'b001; end
    else if (opc == 7'h6F) begin r.regWrite = 1; r.jump = 1; r.resultSrc = 2'b10; r.immSrc = 2'b11; end
    else if (opc == 7'h53) begin
      r.regWrite = 1; r.resultSrc = 2'b11; r.isFp = 1;
      if (fn7 == 7'h20)      r.fpOp = 2'b01;
      else if (fn7 == 7'h01) r.fpOp = 2'b10;
      else if (fn7 == 7'h0C) r.fpOp = 2'b11;
    end
    return r;
  endfunction

  function automatic int latOf(input int d);  return (d == 0) ? 3 : 1; endfunction
  function automatic bit extOf(input int d);  return (d == 0); endfunction

  // Instruction word resident in each stage (0 = bubble) and cycles spent in E
  logic [31:0] eIns [2];
  logic [31:0] mIns [2];
  logic [31:0] wIns [2];
  int          eAge [2];
  bit          modelOk = 1'b0;

  function automatic bit stallOf(input int d);
    return decode(eIns[d]).isFp && (eAge[d] < latOf(d) - 1);
  endfunction

  function automatic logic [18:0] expOf(input int d);
    dec_t dd, de, dm, dw;
    bit st, c;
    logic [2:0] fn3;
    dd  = decode(instrD);
    de  = decode(eIns[d]);
    dm  = decode(mIns[d]);
    dw  = decode(wIns[d]);
    st  = stallOf(d);
    fn3 = eIns[d][14:12];
    if (!extOf(d))       c = zeroE;
    else if (fn3 == 3'd0) c = zeroE;
    else if (fn3 == 3'd1) c = !zeroE;
    else if (fn3 == 3'd4) c = ltE;
    else if (fn3 == 3'd5) c = !ltE;
    else                  c = 1'b0;
    return {dd.immSrc, dd.isFp, de.aluSrc, de.aluCtl, de.resultSrc, de.isFp, de.fpOp,
            !st && (de.jump || (de.branch && c)), st, dm.regWrite, dm.memWrite,
            dw.regWrite, dw.resultSrc};
  endfunction

  // Advance the model's stage occupancy on each clock edge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        eIns[d] <= '0; mIns[d] <= '0; wIns[d] <= '0; eAge[d] <= 0;
      end else begin
        wIns[d] <= mIns[d];
        if (stallOf(d)) begin
          mIns[d] <= '0;
          eAge[d] <= eAge[d] + 1;
        end else begin
          mIns[d] <= eIns[d];
          eIns[d] <= flushE ? 32'h0 : instrD;
          eAge[d] <= 0;
        end
      end
    end
    if (reset) modelOk <= 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (modelOk) begin
      for (int d = 0; d < 2; d++)
        check($sformatf("model_dut%0d", d), {13'h0, act[d]}, {13'h0, expOf(d)});
    end
  end

  // Drive one cycle of inputs, then land on the following negedge
  task automatic tick(input logic [31:0] ins, input logic z = 0, input logic lt = 0,
                      input logic fl = 0, input logic rs = 0);
    #1;
    instrD = ins; zeroE = z; ltE = lt; flushE = fl; reset = rs;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; instrD = NOP; zeroE = 0; ltE = 0; flushE = 0;
    tick(NOP, 0, 0, 0, 1);
    tick(NOP, 0, 0, 0, 1);
    check("rst_regwM",  if0.RegWriteM,   1'b0);
    check("rst_regwW",  if0.RegWriteW,   1'b0);
    check("rst_pcsrc",  if0.PCSrcE,      1'b0);
    check("rst_stall",  if0.FpStallE,    1'b0);
    check("rst_aluctl", if0.ALUControlE, 3'b000);

    // add: E control, then writeback two cycles later
    tick(ADD);
    check("add_aluctlE", if0.ALUControlE, 3'b000);
    check("add_resE",    if0.ResultSrcE,  2'b00);
    tick(NOP);
    check("add_regwM",   if0.RegWriteM,   1'b1);
    tick(NOP);
    check("add_regwW",   if0.RegWriteW,   1'b1);
    check("add_resW",    if0.ResultSrcW,  2'b00);
    tick(SUB);
    check("sub_aluctlE", if0.ALUControlE, 3'b001);

    // fmul with FP_LAT=3: two stall cycles, two bubbles in M
    tick(FMUL);
    check("fmul_isfpD",  if0.IsFpD,    1'b1);
    check("fmul_stall1", if0.FpStallE, 1'b1);
    check("fmul_fpop",   if0.FpOpE,    2'b10);
    check("lat1_nostall", if1.FpStallE, 1'b0);
    tick(NOP);
    check("fmul_stall2", if0.FpStallE, 1'b1);
    check("fmul_bub1",   if0.RegWriteM, 1'b0);
    check("lat1_regwM",  if1.RegWriteM, 1'b1);
    tick(NOP);
    check("fmul_last",   if0.FpStallE, 1'b0);
    check("fmul_bub2",   if0.RegWriteM, 1'b0);
    tick(NOP);
    check("fmul_regwM",  if0.RegWriteM, 1'b1);
    tick(NOP);
    check("fmul_resW",   if0.ResultSrcW, 2'b11);

    // back-to-back FP ops: fdiv enters as fmul leaves
    tick(FMUL);
    tick(FDIV);
    tick(FDIV);
    tick(FDIV);
    check("b2b_fpop",    if0.FpOpE,     2'b11);
    check("b2b_stall",   if0.FpStallE,  1'b1);
    check("b2b_regwM",   if0.RegWriteM, 1'b1);
    repeat (4) tick(NOP);

    // flush during stall is ignored
    tick(FMUL);
    tick(NOP, 0, 0, 1);
    check("flst_isfpE",  if0.IsFpE,    1'b1);
    check("flst_stall",  if0.FpStallE, 1'b1);
    tick(NOP);
    tick(NOP);
    check("flst_regwM",  if0.RegWriteM, 1'b1);
    tick(NOP);

    // sw with and without flush
    tick(SW);
    check("sw_immD",     if0.ImmSrcD,   2'b01);
    tick(NOP);
    check("sw_memwM",    if0.MemWriteM, 1'b1);
    tick(SW, 0, 0, 1);
    check("swfl_alusrc", if0.ALUSrcE,   1'b0);
    tick(NOP);
    check("swfl_memwM",  if0.MemWriteM, 1'b0);

    // branches under both EXT_BRANCH settings
    tick(BNE, 0);
    check("bne_ext1",    if0.PCSrcE, 1'b1);
    check("bne_ext0",    if1.PCSrcE, 1'b0);
    tick(BLT, 0, 1);
    check("blt_ext1",    if0.PCSrcE, 1'b1);
    check("blt_ext0",    if1.PCSrcE, 1'b0);
    tick(BNE, 1);
    check("bnez_ext1",   if0.PCSrcE, 1'b0);
    check("bnez_ext0",   if1.PCSrcE, 1'b1);
    tick(JAL);
    check("jal_pcsrc",   if0.PCSrcE, 1'b1);
    tick(BNE, 0, 0, 1);
    check("bnefl_pcsrc", if0.PCSrcE, 1'b0);

    // reset on the second stall cycle aborts the FP op
    tick(FMUL);
    check("rabt_stall1", if0.FpStallE, 1'b1);
    tick(NOP);
    check("rabt_stall2", if0.FpStallE, 1'b1);
    tick(NOP, 0, 0, 0, 1);
    check("rabt_stall",  if0.FpStallE,  1'b0);
    check("rabt_regwM",  if0.RegWriteM, 1'b0);
    check("rabt_regwW",  if0.RegWriteW, 1'b0);
    tick(NOP);
    check("rabt_regwW2", if0.RegWriteW, 1'b0);

    // undefined opcode decodes to nothing
    tick(UNDEF);
    check("und_immD",    if0.ImmSrcD,   2'b00);
    check("und_isfpD",   if0.IsFpD,     1'b0);
    check("und_alusrcE", if0.ALUSrcE,   1'b0);
    tick(NOP);
    check("und_memwM",   if0.MemWriteM, 1'b0);
    check("und_regwM",   if0.RegWriteM, 1'b0);
    tick(NOP);
    check("und_regwW",   if0.RegWriteW, 1'b0);

    // lw: memory result select flows to W
    tick(LW);
    check("lw_resE",     if0.ResultSrcE, 2'b01);
    check("lw_alusrcE",  if0.ALUSrcE,    1'b1);
    tick(NOP);
    tick(NOP);
    check("lw_resW",     if0.ResultSrcW, 2'b01);
    repeat (3) tick(NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_ctrl_pipe.md
FP_CTRL_PIPE -- requirements
Module: fp_ctrl_pipe

Interface
REQ-001 Parameter FP_LAT, default 3: cycles an FP op occupies Execute; legal range 1..8.
REQ-002 Parameter EXT_BRANCH, default 1: 0 = beq only; 1 = beq/bne/blt/bge.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 InstrD  input  32  instruction in Decode.
REQ-006 ZeroE  input  1  ALU result == 0 in Execute.
REQ-007 LtE  input  1  signed ALU less-than flag in Execute.
REQ-008 FlushE  input  1  hazard-unit request to load a bubble into D/E.
REQ-009 ImmSrcD  output  2  00 I, 01 S, 10 B, 11 J.
REQ-010 IsFpD  output  1  op == 1010011.
REQ-011 ALUSrcE, ALUControlE[2:0], ResultSrcE[1:0], IsFpE, FpOpE[1:0]  outputs  Execute-stage control.
REQ-012 PCSrcE  output  1  taken branch/jump.
REQ-013 FpStallE  output  1  FP op still busy; upstream stages must hold.
REQ-014 RegWriteM, MemWriteM  outputs  1  Memory-stage control.
REQ-015 RegWriteW  output  1; ResultSrcW  output  2  Writeback control.

Function
REQ-016 Decode SHALL be combinational on InstrD: lw 0000011 (RegWrite, ALUSrc, ResultSrc 01, ImmSrc 00); sw 0100011 (MemWrite, ALUSrc, ImmSrc 01); R 0110011 (RegWrite); I-ALU 0010011 (RegWrite, ALUSrc); branch 1100011 (Branch, ImmSrc 10, ALUControl sub); jal 1101111 (RegWrite, Jump, ResultSrc 10, ImmSrc 11); FP 1010011 (RegWrite, ResultSrc 11); any other op: all controls 0.
REQ-017 ALUControl: add 000, sub 001 (R with funct7[5]=1, or branch), and 010, or 011, slt 101; I-type never decodes sub.
REQ-018 FpOp from funct7: 0000000 -> 00 (fadd), 0100000 -> 01 (fsub), 0000001 -> 10 (fmul), 0001100 -> 11 (fdiv), other -> 00; FpOp = 00 when not FP.
REQ-019 Control SHALL pass D -> E -> M -> W through three registers; per-stage latency exactly one cycle each when not stalled.
REQ-020 funct3 SHALL be carried to E; PCSrcE = JumpE | (BranchE & cond); cond: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE; other funct3 -> 0. With EXT_BRANCH = 0, cond = ZeroE regardless of funct3.
REQ-021 Busy counter: when an FP op enters E and FP_LAT > 1, counter loads FP_LAT-1; FpStallE = (counter != 0); counter decrements each cycle to 0.
REQ-022 While FpStallE = 1: D/E register holds; FlushE ignored; E/M register loads a bubble (RegWrite 0, MemWrite 0, ResultSrc 00).
REQ-023 Cycle the counter reaches 0: FP op advances to M next edge; total E occupancy = FP_LAT cycles.
REQ-024 FP_LAT = 1: no stall, FpStallE never asserts, FP op flows like an integer op.
REQ-025 Back-to-back FP ops: second op enters E on the edge the first leaves; counter reloads with no idle cycle.
REQ-026 FlushE with FpStallE = 0: D/E loads all-zero bubble; PCSrcE from the bubble is 0.
REQ-027 PCSrcE SHALL be 0 while FpStallE = 1 (FP op in E is never a branch).
REQ-028 E/M and M/W registers SHALL never stall; they advance every cycle.

Reset
REQ-029 On reset = 1 at a clock edge: all three pipeline registers cleared to zero, counter = 0.
REQ-030 After reset: RegWriteM/W, MemWriteM, PCSrcE, FpStallE, IsFpE, ResultSrcE/W, ALUControlE, ALUSrcE, FpOpE all 0.
REQ-031 Reset mid-FP-stall SHALL abort the op: FpStallE = 0 the cycle after; no FP write reaches W.
REQ-032 Reset SHALL take priority over FlushE and stall hold.

Verification
REQ-033 add x3,x1,x2 (0x002081B3) in D -> E: ALUControlE 000, ResultSrcE 00; two cycles later RegWriteW = 1, ResultSrcW 00.
REQ-034 fmul (funct7 0000001, op 1010011), FP_LAT = 3 -> FpStallE = 1 for 2 cycles, FpOpE 10, two bubbles in M, then RegWriteM = 1, ResultSrcW 11 one cycle later.
REQ-035 bne (funct3 001), ZeroE = 0, EXT_BRANCH = 1 -> PCSrcE = 1; same with EXT_BRANCH = 0 -> PCSrcE = 0.
REQ-036 FlushE = 1 while FpStallE = 1 -> FP op stays in E, completes normally; FlushE = 1 with sw in D -> MemWriteM = 0 two cycles later.
REQ-037 reset asserted on second FP stall cycle -> next cycle FpStallE = 0, RegWriteM = 0, RegWriteW = 0.
REQ-038 Undefined op 0x0000007F -> all D controls 0; RegWriteW, MemWriteM never assert for it.
